// File: rtl/single_vector_serializer.sv
// ============================================================================
// Module      : single_vector_serializer
// Description : Buffers whole vectors of 32-bit words in a DEPTH-entry FIFO
//               and streams them out one word per beat under ready/valid.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module single_vector_serializer #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 2
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        in_valid,
  input  logic [31:0]                                 vector_a [WIDTH],
  output logic [31:0]                                 out_data,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] out_index,
  output logic                                        out_last,
  output logic                                        full,
  output logic                                        overflow
);

  localparam int c_iw = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int c_pw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cw = $clog2(DEPTH + 1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_mem [DEPTH][WIDTH];
  logic [c_pw-1:0]   r_wr_ptr;
  logic [c_pw-1:0]   r_rd_ptr;
  logic [c_cw-1:0]   r_count;
  logic [c_iw-1:0]   r_index;
  logic              r_full;
  logic              r_overflow;

  logic              w_xfer;
  logic              w_last_xfer;
  logic              w_wr;
  logic              w_at_last;
  logic [c_cw-1:0]   w_count_nxt;

  assign out_valid   = (r_state == S_STREAM);
  assign w_at_last   = (r_index == c_iw'(WIDTH - 1));
  assign w_xfer      = out_valid && out_ready;
  assign w_last_xfer = w_xfer && w_at_last;
  // A full FIFO can still take a vector when the head is retiring this cycle.
  assign w_wr        = in_valid && ((r_count < c_cw'(DEPTH)) || w_last_xfer);

  assign out_data  = out_valid ? r_mem[r_rd_ptr][r_index] : 32'd0;
  assign out_index = r_index;
  assign out_last  = out_valid && w_at_last;
  assign full      = r_full;
  assign overflow  = r_overflow;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr, w_last_xfer})
      2'b10:   w_count_nxt = r_count + c_cw'(1);
      2'b01:   w_count_nxt = r_count - c_cw'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_wr) w_state_nxt = S_STREAM;
      S_STREAM: if (w_last_xfer && (r_count == c_cw'(1)) && !w_wr) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_index    <= '0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == c_cw'(DEPTH));
      if (in_valid && !w_wr) begin
        r_overflow <= 1'b1;
      end
      if (w_wr) begin
        r_wr_ptr <= (r_wr_ptr == c_pw'(DEPTH - 1)) ? '0 : r_wr_ptr + c_pw'(1);
      end
      if (w_xfer) begin
        if (w_at_last) begin
          r_index  <= '0;
          r_rd_ptr <= (r_rd_ptr == c_pw'(DEPTH - 1)) ? '0 : r_rd_ptr + c_pw'(1);
        end else begin
          r_index <= r_index + c_iw'(1);
        end
      end
    end
  end

  // Payload storage carries no reset; validity is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (!rst && w_wr) begin
      for (int i = 0; i < WIDTH; i++) begin
        r_mem[r_wr_ptr][i] <= vector_a[i];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_single_vector_serializer.sv
// ============================================================================
// Module      : tb_single_vector_serializer
// Description : Directed self-checking bench for single_vector_serializer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_single_vector_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] vector_a [5];
  logic [31:0] out_data;
  logic        out_valid;
  logic [2:0]  out_index;
  logic        out_last;
  logic        full;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  logic [31:0] va [5];
  logic [31:0] vb [5];
  logic [31:0] vc [5];
  logic [31:0] vd [5];

  single_vector_serializer #(.WIDTH(5), .DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .vector_a  (vector_a),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_last  (out_last),
    .full      (full),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] v [5]);
    for (int i = 0; i < 5; i++) vector_a[i] = v[i];
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) vector_a[i] = va[i];
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    step();
    step();
    rst = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 32'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", out_data); end
    total++; if (out_index !== 3'd0) begin bad++; $display("FAIL reset_index got=%0d exp=0", out_index); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b exp=0", out_last); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_ignore_in got=%b exp=0", out_valid); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    load(va);
    for (int k = 0; k < 5; k++) begin
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid k=%0d got=%b exp=1", k, out_valid); end
      total++; if (out_data !== va[k]) begin bad++; $display("FAIL basic_data k=%0d got=%h exp=%h", k, out_data, va[k]); end
      total++; if (out_index !== 3'(k)) begin bad++; $display("FAIL basic_index k=%0d got=%0d exp=%0d", k, out_index, k); end
      total++; if (out_last !== (k == 4)) begin bad++; $display("FAIL basic_last k=%0d got=%b exp=%b", k, out_last, (k == 4)); end
      step();
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_end_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 32'd0) begin bad++; $display("FAIL basic_end_data got=%h exp=0", out_data); end
  endtask

  task automatic test_stall();
    logic [7:0] pat;
    int got;
    pat = 8'b00101001;
    got = 0;
    out_ready = 1'b0;
    load(va);
    for (int c = 0; c < 40 && got < 5; c++) begin
      out_ready = pat[c % 8];
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid c=%0d got=%b exp=1", c, out_valid); end
      total++; if (out_data !== va[got]) begin bad++; $display("FAIL stall_data c=%0d got=%h exp=%h", c, out_data, va[got]); end
      total++; if (out_index !== 3'(got)) begin bad++; $display("FAIL stall_index c=%0d got=%0d exp=%0d", c, out_index, got); end
      total++; if (out_last !== (got == 4)) begin bad++; $display("FAIL stall_last c=%0d got=%b exp=%b", c, out_last, (got == 4)); end
      if (out_ready) got++;
      step();
    end
    total++; if (got !== 5) begin bad++; $display("FAIL stall_count got=%0d exp=5", got); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_end_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_overflow();
    logic [31:0] e;
    apply_reset();
    out_ready = 1'b0;
    load(va);
    total++; if (full !== 1'b0) begin bad++; $display("FAIL ovf_full_a got=%b exp=0", full); end
    load(vb);
    total++; if (full !== 1'b1) begin bad++; $display("FAIL ovf_full_b got=%b exp=1", full); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_flag_b got=%b exp=0", overflow); end
    load(vc);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag_c got=%b exp=1", overflow); end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL ovf_full_c got=%b exp=1", full); end
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      e = (k < 5) ? va[k] : vb[k - 5];
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ovf_valid k=%0d got=%b exp=1", k, out_valid); end
      total++; if (out_data !== e) begin bad++; $display("FAIL ovf_data k=%0d got=%h exp=%h", k, out_data, e); end
      total++; if (out_index !== 3'(k % 5)) begin bad++; $display("FAIL ovf_index k=%0d got=%0d exp=%0d", k, out_index, k % 5); end
      total++; if (out_last !== ((k % 5) == 4)) begin bad++; $display("FAIL ovf_last k=%0d got=%b exp=%b", k, out_last, ((k % 5) == 4)); end
      total++; if (full !== (k < 5)) begin bad++; $display("FAIL ovf_full k=%0d got=%b exp=%b", k, full, (k < 5)); end
      step();
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ovf_end_valid got=%b exp=0", out_valid); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
  endtask

  task automatic test_coincident();
    logic [31:0] e;
    apply_reset();
    out_ready = 1'b0;
    load(va);
    load(vb);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      total++; if (out_data !== va[k]) begin bad++; $display("FAIL coin_head k=%0d got=%h exp=%h", k, out_data, va[k]); end
      step();
    end
    total++; if (out_last !== 1'b1) begin bad++; $display("FAIL coin_last got=%b exp=1", out_last); end
    load(vd);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL coin_overflow got=%b exp=0", overflow); end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL coin_full got=%b exp=1", full); end
    for (int k = 0; k < 10; k++) begin
      e = (k < 5) ? vb[k] : vd[k - 5];
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL coin_valid k=%0d got=%b exp=1", k, out_valid); end
      total++; if (out_data !== e) begin bad++; $display("FAIL coin_data k=%0d got=%h exp=%h", k, out_data, e); end
      total++; if (out_index !== 3'(k % 5)) begin bad++; $display("FAIL coin_index k=%0d got=%0d exp=%0d", k, out_index, k % 5); end
      total++; if (full !== (k < 5)) begin bad++; $display("FAIL coin_full k=%0d got=%b exp=%b", k, full, (k < 5)); end
      step();
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL coin_end_valid got=%b exp=0", out_valid); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL coin_end_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    out_ready = 1'b0;
    load(va);
    load(vb);
    load(vc);
    out_ready = 1'b1;
    step();
    step();
    step();
    total++; if (out_index !== 3'd3) begin bad++; $display("FAIL mid_pre_index got=%0d exp=3", out_index); end
    for (int i = 0; i < 5; i++) vector_a[i] = vd[i];
    rst = 1'b1; in_valid = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", out_valid); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL mid_full got=%b exp=0", full); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL mid_overflow got=%b exp=0", overflow); end
    total++; if (out_data !== 32'd0) begin bad++; $display("FAIL mid_data got=%h exp=0", out_data); end
    for (int c = 0; c < 3; c++) begin
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_quiet c=%0d got=%b exp=0", c, out_valid); end
    end
    load(vd);
    for (int k = 0; k < 5; k++) begin
      total++; if (out_data !== vd[k]) begin bad++; $display("FAIL mid_next_data k=%0d got=%h exp=%h", k, out_data, vd[k]); end
      total++; if (out_index !== 3'(k)) begin bad++; $display("FAIL mid_next_index k=%0d got=%0d exp=%0d", k, out_index, k); end
      step();
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_end_valid got=%b exp=0", out_valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    va[0] = 32'h3F800000; va[1] = 32'h40000000; va[2] = 32'h40400000;
    va[3] = 32'h40800000; va[4] = 32'h40A00000;
    vb[0] = 32'h7FC00001; vb[1] = 32'h80000000; vb[2] = 32'hFF800000;
    vb[3] = 32'h00000001; vb[4] = 32'hDEADBEEF;
    vc[0] = 32'h11111111; vc[1] = 32'h22222222; vc[2] = 32'h33333333;
    vc[3] = 32'h44444444; vc[4] = 32'h55555555;
    vd[0] = 32'hC0490FDB; vd[1] = 32'h3EAAAAAB; vd[2] = 32'h7F7FFFFF;
    vd[3] = 32'h00800000; vd[4] = 32'hBF800000;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) vector_a[i] = 32'd0;
    #1;
    test_reset();
    test_basic();
    test_stall();
    test_overflow();
    test_coincident();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/single_vector_serializer.md
SINGLE_VECTOR_SERIALIZER -- requirements
Module: single_vector_serializer

Interface
REQ-001 Parameter WIDTH, default 5, SHALL set the number of single-precision elements per vector.
REQ-002 Parameter DEPTH, default 2, SHALL set the number of whole vectors buffered; legal range DEPTH >= 1.
REQ-003 clk  input  1  SHALL be the only clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 in_valid  input  1  SHALL be a one-cycle pulse qualifying vector_a; there is no input backpressure.
REQ-006 vector_a  input  32 x [WIDTH] unpacked  SHALL carry IEEE-754 single words; element 0 is sent first.
REQ-007 out_data  output  32  SHALL be the current element word.
REQ-008 out_valid  output  1  SHALL be high while a buffered element is presented.
REQ-009 out_ready  input  1  SHALL be the downstream accept; a beat transfers when out_valid && out_ready.
REQ-010 out_index  output  $clog2(WIDTH) (min 1)  SHALL be the element number of out_data.
REQ-011 out_last  output  1  SHALL be high when out_valid and out_index == WIDTH-1.
REQ-012 full  output  1  SHALL be high when DEPTH vectors are buffered.
REQ-013 overflow  output  1  SHALL be a sticky flag set when an input vector is dropped.

Function
REQ-014 Storage SHALL be a DEPTH-entry FIFO of whole vectors with write pointer, read pointer and count; pointers SHALL wrap from DEPTH-1 to 0 for any DEPTH, not only powers of two.
REQ-015 FSM SHALL have two states: IDLE (count == 0, out_valid low) and STREAM (count > 0, out_valid high).
REQ-016 IDLE -> STREAM on accepted write; STREAM -> IDLE on last-beat transfer when count == 1 and no simultaneous accepted write; otherwise remain.
REQ-017 Write acceptance: vector SHALL be captured when in_valid && (count < DEPTH || last-beat transfer in the same cycle).
REQ-018 in_valid with count == DEPTH and no same-cycle last-beat transfer SHALL drop the vector, leave the FIFO unchanged and set overflow at that edge.
REQ-019 Latency: vector accepted at edge N into an empty FIFO SHALL present element 0 with out_valid high in the cycle after edge N.
REQ-020 Data SHALL pass bit-exact; no arithmetic, rounding or NaN handling is applied to the words.
REQ-021 out_data SHALL equal head_vector[out_index] while out_valid, and 0 while out_valid is low.
REQ-022 While out_valid && !out_ready, out_data, out_index and out_last SHALL hold stable.
REQ-023 Each transfer SHALL increment out_index; transfer at WIDTH-1 SHALL wrap out_index to 0, advance the read pointer and decrement count.
REQ-024 Simultaneous accepted write and last-beat transfer SHALL leave count unchanged.
REQ-025 Back-to-back buffered vectors SHALL stream with no idle cycle between element WIDTH-1 and the next element 0 while out_ready is high.
REQ-026 full SHALL be a registered function of count (count == DEPTH) only.
REQ-027 WIDTH == 1 SHALL be supported: every beat is out_last.

Reset
REQ-028 With rst high at an edge: count, pointers and out_index SHALL become 0; out_valid, out_last, full and overflow SHALL be 0; out_data SHALL be 0.
REQ-029 in_valid and out_ready SHALL be ignored in any cycle where rst is high.
REQ-030 rst asserted mid-stream SHALL discard all buffered vectors with no partial beat emitted after the reset edge.
REQ-031 Stored vector payload registers need no reset.

Verification
REQ-032 Reset, then in_valid with {1.0,2.0,3.0,4.0,5.0}, out_ready=1 -> beats 0x3F800000, 0x40000000, 0x40400000, 0x40800000, 0x40A00000 on 5 consecutive cycles starting the cycle after in_valid; out_index 0..4; out_last only on beat 4; then out_valid=0.
REQ-033 Same vector, out_ready toggling 1,0,0,1,0,1... -> each word held stable while stalled, all 5 words delivered in order, none duplicated.
REQ-034 DEPTH=2, out_ready=0, three in_valid pulses A, B, C -> full=1 after B, C dropped, overflow=1; then out_ready=1 -> 10 beats A0..A4, B0..B4, full falls after A4.
REQ-035 Full FIFO, in_valid with D coincident with last-beat transfer of head -> D accepted, overflow stays 0, count stays 2, D streams after the remaining vector.
REQ-036 Stream in progress, rst high one cycle after beat 2 -> out_valid=0, full=0 and overflow=0 the cycle after the reset edge; next vector starts at out_index 0 with its own element 0.
